// File: rtl/otter_iobus_timer.sv
// otter_iobus_timer: memory-mapped countdown timer on the OTTER MCU IOBUS.
// Registers: CTRL 0x00, LOAD 0x04, COUNT 0x08 (RO), STATUS 0x0C, CMP 0x10.
// Optional PWM output and CMP register are enabled by defining TMR_PWM_EN.
module otter_iobus_timer #(
   parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] IOBUS_ADDR,
   input  logic [31:0] IOBUS_OUT,
   input  logic        IOBUS_WR,
   output logic [31:0] TMR_DOUT,
   output logic        INTR
`ifdef TMR_PWM_EN
   ,
   output logic        PWM
`endif
);

   localparam int unsigned OFF_W   = 3;
   localparam logic [OFF_W-1:0] OFF_CTRL   = 3'd0;
   localparam logic [OFF_W-1:0] OFF_LOAD   = 3'd1;
   localparam logic [OFF_W-1:0] OFF_COUNT  = 3'd2;
   localparam logic [OFF_W-1:0] OFF_STATUS = 3'd3;
   localparam logic [OFF_W-1:0] OFF_CMP    = 3'd4;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t                state, state_nxt;
   logic                  ctrl_en, ctrl_auto, ctrl_ie;
   logic [PRESCALE_W-1:0] ctrl_psc;
   logic [PRESCALE_W-1:0] psc_cnt;
   logic [31:0]           load_val;
   logic [31:0]           count;
   logic                  exp_flag;

   logic                  hit;
   logic [OFF_W-1:0]      off;
   logic                  wr_ctrl, wr_load, wr_status;
   logic                  start, stop, tick, expire;
   logic                  unused_addr;

   // Address decode: block spans 32 bytes, byte offset bits are ignored
   assign hit         = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
   assign off         = IOBUS_ADDR[4:2];
   assign unused_addr = ^IOBUS_ADDR[1:0];

   assign wr_ctrl   = IOBUS_WR && hit && (off == OFF_CTRL);
   assign wr_load   = IOBUS_WR && hit && (off == OFF_LOAD);
   assign wr_status = IOBUS_WR && hit && (off == OFF_STATUS);

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic: an EN=0 CTRL write outranks a same-edge expiry
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            if (stop)                        state_nxt = IDLE;
            else if (expire && !ctrl_auto)   state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM-derived control strobes and interrupt
   always_comb begin
      start  = wr_ctrl && IOBUS_OUT[0] && (state == IDLE);
      stop   = wr_ctrl && !IOBUS_OUT[0] && (state == RUN);
      tick   = (state == RUN) && (psc_cnt == ctrl_psc);
      expire = tick && (count == 32'd0) && !stop;
      INTR   = exp_flag && ctrl_ie;
   end

   // Control, reload, counter, prescaler and sticky expiry flag
   always_ff @(posedge CLK) begin
      if (RST) begin
         ctrl_en   <= 1'b0;
         ctrl_auto <= 1'b0;
         ctrl_ie   <= 1'b0;
         ctrl_psc  <= '0;
         load_val  <= 32'd0;
         count     <= 32'd0;
         psc_cnt   <= '0;
         exp_flag  <= 1'b0;
      end else begin
         ctrl_en <= (state_nxt == RUN);
         if (wr_ctrl) begin
            ctrl_auto <= IOBUS_OUT[1];
            ctrl_ie   <= IOBUS_OUT[2];
            ctrl_psc  <= IOBUS_OUT[8 +: PRESCALE_W];
         end
         if (wr_load) load_val <= IOBUS_OUT;

         // Start uses the LOAD value from before any same-edge LOAD write
         if (start) begin
            count   <= load_val;
            psc_cnt <= '0;
         end else if ((state == RUN) && !stop) begin
            psc_cnt <= tick ? '0 : psc_cnt + PRESCALE_W'(1);
            if (tick) begin
               if (count != 32'd0) count <= count - 32'd1;
               else if (ctrl_auto) count <= load_val;
            end
         end

         // Expiry set beats a same-edge software clear
         if (expire)                        exp_flag <= 1'b1;
         else if (wr_status && IOBUS_OUT[0]) exp_flag <= 1'b0;
      end
   end

`ifdef TMR_PWM_EN
   logic [31:0] cmp_val;
   logic        wr_cmp;

   assign wr_cmp = IOBUS_WR && hit && (off == OFF_CMP);

   // Compare register and registered PWM output
   always_ff @(posedge CLK) begin
      if (RST) begin
         cmp_val <= 32'd0;
         PWM     <= 1'b0;
      end else begin
         if (wr_cmp) cmp_val <= IOBUS_OUT;
         PWM <= (state == RUN) && (count < cmp_val);
      end
   end
`endif

   // Combinational read mux; zero outside the block
   always_comb begin
      TMR_DOUT = 32'd0;
      if (hit) begin
         case (off)
            OFF_CTRL:   TMR_DOUT = 32'({ctrl_psc, 5'b0, ctrl_ie, ctrl_auto, ctrl_en});
            OFF_LOAD:   TMR_DOUT = load_val;
            OFF_COUNT:  TMR_DOUT = count;
            OFF_STATUS: TMR_DOUT = 32'(exp_flag);
`ifdef TMR_PWM_EN
            OFF_CMP:    TMR_DOUT = cmp_val;
`endif
            default:    TMR_DOUT = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_otter_iobus_timer.sv
// Directed bench for otter_iobus_timer; PWM steps included when TMR_PWM_EN is defined.
module tb_otter_iobus_timer;

   localparam logic [31:0] BASE = 32'h1100_0100;
   localparam logic [31:0] O_CTRL = 32'h00, O_LOAD = 32'h04, O_COUNT = 32'h08,
                           O_STAT = 32'h0C, O_CMP  = 32'h10;

   logic        CLK;
   logic        RST;
   logic [31:0] IOBUS_ADDR;
   logic [31:0] IOBUS_OUT;
   logic        IOBUS_WR;
   logic [31:0] TMR_DOUT;
   logic        INTR;
`ifdef TMR_PWM_EN
   logic        PWM;
`endif

   int tests = 0;
   int fails = 0;

   otter_iobus_timer dut (
      .CLK        (CLK),
      .RST        (RST),
      .IOBUS_ADDR (IOBUS_ADDR),
      .IOBUS_OUT  (IOBUS_OUT),
      .IOBUS_WR   (IOBUS_WR),
      .TMR_DOUT   (TMR_DOUT),
      .INTR       (INTR)
`ifdef TMR_PWM_EN
      ,
      .PWM        (PWM)
`endif
   );

   initial CLK = 1'b0;
   always #10 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] expv);
      IOBUS_ADDR = BASE + off;
      #1;
      chk(tag, TMR_DOUT, expv);
   endtask

   // Drive one write in the low phase; returns at the negedge after the commit edge
   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      IOBUS_ADDR = addr;
      IOBUS_OUT  = data;
      IOBUS_WR   = 1'b1;
      @(negedge CLK);
      IOBUS_WR   = 1'b0;
      IOBUS_OUT  = 32'd0;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; IOBUS_WR = 1'b0; IOBUS_ADDR = 32'd0; IOBUS_OUT = 32'd0;
      step(2);
      RST = 1'b0;
      step(1);

      // Reset state
      rd("rst_ctrl", O_CTRL, 32'd0);
      rd("rst_load", O_LOAD, 32'd0);
      rd("rst_count", O_COUNT, 32'd0);
      rd("rst_status", O_STAT, 32'd0);
      chk("rst_intr", 32'(INTR), 32'd0);
      step(1);

      // One-shot: LOAD=3, EN|IE, PSC=0
      wr(BASE + O_LOAD, 32'd3);
      wr(BASE + O_CTRL, 32'h5);
      rd("os_count3", O_COUNT, 32'd3);
      step(1); rd("os_count2", O_COUNT, 32'd2);
      step(1); rd("os_count1", O_COUNT, 32'd1);
      step(1); rd("os_count0", O_COUNT, 32'd0);
      rd("os_exp_before", O_STAT, 32'd0);
      chk("os_intr_before", 32'(INTR), 32'd0);
      step(1);
      rd("os_exp", O_STAT, 32'd1);
      chk("os_intr", 32'(INTR), 32'd1);
      rd("os_ctrl_en_clr", O_CTRL, 32'h4);
      rd("os_count_hold", O_COUNT, 32'd0);
      wr(BASE + O_STAT, 32'd1);
      chk("os_intr_clr", 32'(INTR), 32'd0);
      rd("os_exp_clr", O_STAT, 32'd0);

      // Auto-reload with prescale: LOAD=2, EN|AUTO, PSC=2
      wr(BASE + O_LOAD, 32'd2);
      wr(BASE + O_CTRL, 32'h0203);
      for (int k = 0; k < 9; k++) begin
         rd("ar_count", O_COUNT, 32'(2 - k / 3));
         if (k == 8) rd("ar_exp_before", O_STAT, 32'd0);
         step(1);
      end
      rd("ar_exp", O_STAT, 32'd1);
      rd("ar_reload", O_COUNT, 32'd2);
      chk("ar_intr_masked", 32'(INTR), 32'd0);
      rd("ar_ctrl", O_CTRL, 32'h0203);
      wr(BASE + O_STAT, 32'd1);
      rd("ar_exp_clr", O_STAT, 32'd0);

      // Collision: clear lands on the next expiry edge, nine cycles after the last
      step(7);
      rd("col_count0", O_COUNT, 32'd0);
      wr(BASE + O_STAT, 32'd1);
      rd("col_exp_wins", O_STAT, 32'd1);
      rd("col_reload", O_COUNT, 32'd2);

      // Reset mid-count with EXP and IE set
      wr(BASE + O_CTRL, 32'h0);
      wr(BASE + O_LOAD, 32'd10);
      wr(BASE + O_CTRL, 32'h5);
      chk("rm_intr_pre", 32'(INTR), 32'd1);
      step(5);
      rd("rm_count5", O_COUNT, 32'd5);
      RST = 1'b1;
      step(1);
      RST = 1'b0;
      rd("rm_count", O_COUNT, 32'd0);
      rd("rm_ctrl", O_CTRL, 32'd0);
      rd("rm_load", O_LOAD, 32'd0);
      rd("rm_status", O_STAT, 32'd0);
      chk("rm_intr", 32'(INTR), 32'd0);

      // Stop write on the expiry edge: stop wins, no EXP
      wr(BASE + O_CTRL, 32'h1);
      wr(BASE + O_CTRL, 32'h0);
      rd("sc_exp", O_STAT, 32'd0);
      rd("sc_ctrl", O_CTRL, 32'd0);
      step(2);
      rd("sc_exp_idle", O_STAT, 32'd0);

      // Decode: out-of-range, unrelated, read-only and reserved writes are ignored
      wr(BASE + O_LOAD, 32'h55);
      wr(BASE + 32'h20, 32'hDEAD);
      wr(32'h0000_2000, 32'hDEAD);
      wr(BASE + O_COUNT, 32'hDEAD);
      wr(BASE + 32'h14, 32'hDEAD);
      rd("dec_load", O_LOAD, 32'h55);
      rd("dec_ctrl", O_CTRL, 32'd0);
      rd("dec_count", O_COUNT, 32'd0);
      rd("dec_status", O_STAT, 32'd0);
      step(1);
      IOBUS_ADDR = BASE + 32'h20; #1;
      chk("dec_dout_past_end", TMR_DOUT, 32'd0);
      IOBUS_ADDR = 32'h0000_2000; #1;
      chk("dec_dout_unrelated", TMR_DOUT, 32'd0);
      rd("dec_byte_off", 32'h05, 32'h55);
      rd("dec_rsvd", 32'h14, 32'd0);
      step(1);

`ifdef TMR_PWM_EN
      // PWM: LOAD=9, CMP=4, AUTO, PSC=0 -> high 4 of every 10 cycles
      wr(BASE + O_LOAD, 32'd9);
      wr(BASE + O_CMP, 32'd4);
      rd("pwm_cmp", O_CMP, 32'd4);
      wr(BASE + O_CTRL, 32'h3);
      chk("pwm_start_low", 32'(PWM), 32'd0);
      for (int k = 1; k <= 20; k++) begin
         int prev_cnt;
         step(1);
         prev_cnt = 9 - ((k - 1) % 10);
         chk("pwm_wave", 32'(PWM), (prev_cnt < 4) ? 32'd1 : 32'd0);
      end
      wr(BASE + O_CTRL, 32'h0);
      step(1);
      chk("pwm_idle", 32'(PWM), 32'd0);
      rd("pwm_ctrl_idle", O_CTRL, 32'd0);
`else
      wr(BASE + O_CMP, 32'hDEAD);
      rd("nopwm_cmp", O_CMP, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
